// File: rtl/avalon_verin_ocimem_pkg.sv
// Shared types and constants for the Nios II on-chip debug memory stage.
package avalon_verin_ocimem_pkg;

  localparam int unsigned RAM_WORDS = 256;

  // jdo field positions
  localparam int unsigned JDO_RD_BIT  = 35;
  localparam int unsigned JDO_ADDR_HI = 33;
  localparam int unsigned JDO_ADDR_LO = 26;
  localparam int unsigned JDO_DATA_HI = 34;
  localparam int unsigned JDO_DATA_LO = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_JRD,
    ST_JCAP,
    ST_JWR,
    ST_CACC,
    ST_CACK
  } state_t;

endpackage

// File: rtl/avalon_verin_cpu_debug_ocimem_ram.sv
// Single-port debug RAM: byte-enable write, registered (1-cycle) read.
module avalon_verin_cpu_debug_ocimem_ram
  import avalon_verin_ocimem_pkg::*;
#(
  parameter int unsigned DEPTH = RAM_WORDS,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic [AW-1:0] i_addr,
  input  logic          i_we,
  input  logic [3:0]    i_be,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_q;

  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (i_be[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
    r_q <= r_mem[i_addr];
  end

  assign o_rdata = r_q;

endmodule

// File: rtl/avalon_verin_cpu_debug_ocimem.sv
// Debug memory stage: JTAG reads/writes and CPU Avalon accesses share one RAM.
// Optional streaming reads on take_no_action_ocimem_a: OCIMEM_JTAG_AUTOINC_EN.
module avalon_verin_cpu_debug_ocimem
  import avalon_verin_ocimem_pkg::*;
#(
  parameter int unsigned RAM_WORDS = avalon_verin_ocimem_pkg::RAM_WORDS
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [37:0] jdo,
  input  logic        take_action_ocimem_a,
  input  logic        take_no_action_ocimem_a,
  input  logic        take_action_ocimem_b,
  input  logic [7:0]  address,
  input  logic        chipselect,
  input  logic        read,
  input  logic        write,
  input  logic [3:0]  byteenable,
  input  logic [31:0] writedata,
  input  logic        debugaccess,
  output logic [31:0] readdata,
  output logic        waitrequest,
  output logic [31:0] MonDReg,
  output logic [7:0]  MonAReg
);

  state_t      r_state, w_next;
  logic        r_jrd_pend, r_jwr_pend;
  logic [31:0] r_readdata, r_mon_d;
  logic [7:0]  r_mon_a;

  logic        w_autoinc, w_cpu_req, w_jtag_incoming, w_jrd_set;
  logic        w_unused;
  logic [7:0]  w_ram_addr;
  logic        w_ram_we;
  logic [3:0]  w_ram_be;
  logic [31:0] w_ram_wdata, w_ram_q;

`ifdef OCIMEM_JTAG_AUTOINC_EN
  assign w_autoinc = take_no_action_ocimem_a;
  assign w_unused  = ^{jdo[37:36], jdo[2:0]};
`else
  assign w_autoinc = 1'b0;
  assign w_unused  = ^{jdo[37:36], jdo[2:0], take_no_action_ocimem_a};
`endif

  assign w_cpu_req       = chipselect & (read | write);
  assign w_jrd_set       = (take_action_ocimem_a & jdo[JDO_RD_BIT]) | w_autoinc;
  // A strobe in flight this cycle becomes a pending flag next cycle; holding
  // the CPU back here keeps JTAG ahead of a simultaneous CPU request.
  assign w_jtag_incoming = take_action_ocimem_b | w_jrd_set;

  always_comb begin
    w_next      = r_state;
    w_ram_addr  = r_mon_a;
    w_ram_we    = 1'b0;
    w_ram_be    = '1;
    w_ram_wdata = r_mon_d;
    unique case (r_state)
      ST_IDLE: begin
        if (r_jwr_pend)                         w_next = ST_JWR;
        else if (r_jrd_pend)                    w_next = ST_JRD;
        else if (w_cpu_req && !w_jtag_incoming) w_next = ST_CACC;
      end
      ST_JWR: begin
        w_ram_we = 1'b1;
        w_next   = ST_IDLE;
      end
      ST_JRD:  w_next = ST_JCAP;
      ST_JCAP: w_next = ST_IDLE;
      ST_CACC: begin
        w_ram_addr  = address;
        w_ram_we    = write & debugaccess;
        w_ram_be    = byteenable;
        w_ram_wdata = writedata;
        w_next      = ST_CACK;
      end
      ST_CACK: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_jrd_pend <= 1'b0;
      r_jwr_pend <= 1'b0;
      r_readdata <= '0;
      r_mon_d    <= '0;
      r_mon_a    <= '0;
    end else begin
      r_state    <= w_next;
      // A new strobe re-arms a flag even in the cycle that consumes it.
      r_jwr_pend <= take_action_ocimem_b | (r_jwr_pend & (r_state != ST_JWR));
      r_jrd_pend <= w_jrd_set | (r_jrd_pend & (r_state != ST_JRD));

      if (take_action_ocimem_a)  r_mon_a <= jdo[JDO_ADDR_HI:JDO_ADDR_LO];
      else if (w_autoinc)        r_mon_a <= r_mon_a + 8'd1;
      else if (r_state == ST_JWR) r_mon_a <= r_mon_a + 8'd1;

      if (take_action_ocimem_b)    r_mon_d <= jdo[JDO_DATA_HI:JDO_DATA_LO];
      else if (r_state == ST_JCAP) r_mon_d <= w_ram_q;

      if (r_state == ST_CACK) r_readdata <= w_ram_q;
    end
  end

  avalon_verin_cpu_debug_ocimem_ram #(
    .DEPTH (RAM_WORDS)
  ) u_ram (
    .clk     (clk),
    .i_addr  (w_ram_addr),
    .i_we    (w_ram_we),
    .i_be    (w_ram_be),
    .i_wdata (w_ram_wdata),
    .o_rdata (w_ram_q)
  );

  assign readdata    = r_readdata;
  assign waitrequest = (r_state != ST_CACK);
  assign MonDReg     = r_mon_d;
  assign MonAReg     = r_mon_a;

endmodule

// File: tb/tb_avalon_verin_cpu_debug_ocimem.sv
// Scoreboard bench: drivers push timed expectations from a word-array model,
// a negedge monitor compares them against the DUT outputs.
module tb_avalon_verin_cpu_debug_ocimem;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [37:0] jdo = '0;
  logic        ta_a = 1'b0, tna_a = 1'b0, ta_b = 1'b0;
  logic [7:0]  address = '0;
  logic        chipselect = 1'b0, read = 1'b0, write = 1'b0;
  logic [3:0]  byteenable = '0;
  logic [31:0] writedata = '0;
  logic        debugaccess = 1'b0;
  logic [31:0] readdata, MonDReg;
  logic        waitrequest;
  logic [7:0]  MonAReg;

  avalon_verin_cpu_debug_ocimem #(.RAM_WORDS(256)) dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .jdo                     (jdo),
    .take_action_ocimem_a    (ta_a),
    .take_no_action_ocimem_a (tna_a),
    .take_action_ocimem_b    (ta_b),
    .address                 (address),
    .chipselect              (chipselect),
    .read                    (read),
    .write                   (write),
    .byteenable              (byteenable),
    .writedata               (writedata),
    .debugaccess             (debugaccess),
    .readdata                (readdata),
    .waitrequest             (waitrequest),
    .MonDReg                 (MonDReg),
    .MonAReg                 (MonAReg)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // reference model
  logic [31:0] m_mem [256];
  logic [7:0]  m_a = '0;
  logic [31:0] m_d = '0;

  typedef struct { int due; int sig; logic [31:0] exp; } chk_t;
  typedef struct { int due; logic [31:0] exp; bit is_rd; } cpu_t;
  chk_t chk_q[$];
  cpu_t cpu_q[$];

  int n_chk = 0, n_pass = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
  endfunction

  function automatic void expect_at(int due, int sig, logic [31:0] exp);
    chk_q.push_back('{due: due, sig: sig, exp: exp});
  endfunction

  // monitor
  bit          rd_next = 1'b0;
  logic [31:0] rd_exp = '0;
  cpu_t        mon_e;
  logic [31:0] mon_act;
  string       mon_name;

  always @(negedge clk) begin
    if (rd_next) begin
      rd_next = 1'b0;
      check("cpu_readdata", readdata, rd_exp);
    end
    if (reset_n && waitrequest === 1'b0) begin
      if (cpu_q.size() == 0) begin
        check("spurious_ack", {31'b0, waitrequest}, 32'd1);
      end else begin
        mon_e = cpu_q.pop_front();
        check("ack_cycle", 32'(cyc), 32'(mon_e.due));
        if (mon_e.is_rd) begin
          rd_next = 1'b1;
          rd_exp  = mon_e.exp;
        end
      end
    end
    for (int i = chk_q.size() - 1; i >= 0; i--) begin
      if (chk_q[i].due == cyc) begin
        case (chk_q[i].sig)
          0:       begin mon_act = MonDReg;               mon_name = "MonDReg";     end
          1:       begin mon_act = {24'b0, MonAReg};      mon_name = "MonAReg";     end
          2:       begin mon_act = {31'b0, waitrequest};  mon_name = "waitrequest"; end
          default: begin mon_act = readdata;              mon_name = "readdata";    end
        endcase
        check(mon_name, mon_act, chk_q[i].exp);
        chk_q.delete(i);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic jtag_a(input logic [7:0] a, input bit rd);
    int n = cyc;
    jdo = {6'($urandom()), $urandom()};
    jdo[35] = rd;
    jdo[33:26] = a;
    ta_a = 1'b1;
    m_a = a;
    expect_at(n + 1, 1, {24'b0, m_a});
    if (rd) begin
      m_d = m_mem[a];
      expect_at(n + 4, 0, m_d);
    end
    tick();
    ta_a = 1'b0;
    if (rd) repeat (3) tick();
  endtask

  task automatic jtag_b(input logic [31:0] d);
    int n = cyc;
    jdo = {6'($urandom()), $urandom()};
    jdo[34:3] = d;
    ta_b = 1'b1;
    m_d = d;
    m_mem[m_a] = d;
    m_a = m_a + 8'd1;
    expect_at(n + 1, 0, d);
    expect_at(n + 3, 1, {24'b0, m_a});
    tick();
    ta_b = 1'b0;
    repeat (2) tick();
  endtask

  task automatic jtag_autoinc();
    int n = cyc;
    tna_a = 1'b1;
`ifdef OCIMEM_JTAG_AUTOINC_EN
    m_a = m_a + 8'd1;
    m_d = m_mem[m_a];
`endif
    expect_at(n + 1, 1, {24'b0, m_a});
    expect_at(n + 4, 0, m_d);
    tick();
    tna_a = 1'b0;
    repeat (3) tick();
  endtask

  // with_jwr: raise an ocimem_b strobe in the same cycle as the request
  task automatic cpu(input logic [7:0] a, input bit wr, input logic [3:0] be,
                     input logic [31:0] d, input bit dbg,
                     input bit with_jwr, input logic [31:0] jd);
    int n = cyc;
    int extra = 0;
    bit got = 1'b0;
    address = a; chipselect = 1'b1; read = !wr; write = wr;
    byteenable = be; writedata = d; debugaccess = dbg;
    if (with_jwr) begin
      jdo = {6'($urandom()), $urandom()};
      jdo[34:3] = jd;
      ta_b = 1'b1;
      m_d = jd;
      m_mem[m_a] = jd;
      m_a = m_a + 8'd1;
      expect_at(n + 1, 0, jd);
      expect_at(n + 3, 1, {24'b0, m_a});
      extra = 3;
    end
    cpu_q.push_back('{due: n + 2 + extra, exp: m_mem[a], is_rd: !wr});
    if (wr && dbg)
      for (int b = 0; b < 4; b++)
        if (be[b]) m_mem[a][8*b +: 8] = d[8*b +: 8];
    for (int k = 0; k < 20 && !got; k++) begin
      tick();
      ta_b = 1'b0;
      if (waitrequest === 1'b0) got = 1'b1;
    end
    chipselect = 1'b0; read = 1'b0; write = 1'b0;
    if (!got) begin
      check("cpu_ack_timeout", {31'b0, waitrequest}, 32'd0);
      void'(cpu_q.pop_back());
    end
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (2) @(posedge clk);
    #1;
    expect_at(cyc, 2, 32'd1);
    expect_at(cyc, 3, 32'd0);
    expect_at(cyc, 0, 32'd0);
    expect_at(cyc, 1, 32'd0);
    tick();
    reset_n = 1'b1;
    tick();

    // fill RAM through streaming JTAG writes; MonAReg wraps back to 0
    jtag_a(8'h00, 1'b0);
    for (int i = 0; i < 256; i++) jtag_b($urandom());

    // JTAG read
    jtag_a(8'h10, 1'b0);
    jtag_b(32'hDEADBEEF);
    jtag_a(8'h10, 1'b1);

    // JTAG write at top address wraps MonAReg
    jtag_a(8'hFF, 1'b0);
    jtag_b(32'h12345678);
    cpu(8'hFF, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0);

    // CPU write gating by byteenable and debugaccess
    cpu(8'h20, 1'b1, 4'b0011, 32'hAABBCCDD, 1'b1, 1'b0, 32'h0);
    cpu(8'h20, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    cpu(8'h20, 1'b1, 4'b1111, 32'h01020304, 1'b0, 1'b0, 32'h0);
    cpu(8'h20, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0);

    // arbitration: JWR to 0x05 ahead of a simultaneous CPU read of 0x05
    jtag_a(8'h05, 1'b0);
    cpu(8'h05, 1'b0, 4'h0, 32'h0, 1'b0, 1'b1, 32'hCAFEF00D);

    // streaming reads
    jtag_a(8'h40, 1'b0);
    repeat (3) jtag_autoinc();

    // randomized mix
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 4))
        0: cpu(8'($urandom()), 1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        1: cpu(8'($urandom()), 1'b1, 4'($urandom()), $urandom(),
               1'($urandom()), 1'b0, 32'h0);
        2: jtag_a(8'($urandom()), 1'($urandom()));
        3: jtag_b($urandom());
        default: jtag_autoinc();
      endcase
    end

    // reset during CACC
    n = cyc;
    address = 8'h33; chipselect = 1'b1; read = 1'b1; write = 1'b0;
    tick();
    reset_n = 1'b0;
    chipselect = 1'b0; read = 1'b0;
    expect_at(n + 1, 2, 32'd1);
    expect_at(n + 1, 0, 32'd0);
    expect_at(n + 1, 1, 32'd0);
    expect_at(n + 1, 3, 32'd0);
    repeat (2) tick();
    reset_n = 1'b1;
    m_a = '0;
    m_d = '0;
    tick();
    cpu(8'h33, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    jtag_a(8'h10, 1'b1);

    repeat (8) tick();
    if (chk_q.size() != 0 || cpu_q.size() != 0)
      check("unserviced_expectations", 32'(chk_q.size() + cpu_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
